// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the async FIFO: pops words without over-reading and
// presents them on a registered valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CW    = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CW-1:0]    rd_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] m_data_q, m_data_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic             m_valid_q, m_valid_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop, push;

  // Pop strobe depends only on registered occupancy, so it never waits on m_ready.
  assign rinc = rrst_n & ~rempty & ~flush & (state_q != TWO);
  assign push = rinc;
  assign pop  = m_valid_q & m_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    skid_d   = skid_q;
    count_d  = count_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d  = ONE;
          m_data_d = rdata;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = TWO;
          skid_d  = rdata;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          m_data_d = rdata;
        end
      end
      TWO: begin
        if (pop) begin
          state_d  = ONE;
          m_data_d = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
    if (pop) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end
    m_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q   <= EMPTY;
      m_data_q  <= '0;
      skid_q    <= '0;
      m_valid_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      m_data_q  <= m_data_d;
      skid_q    <= skid_d;
      m_valid_q <= m_valid_d;
      count_q   <= count_d;
    end
  end

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign rd_count = count_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO source, negedge scoreboard and
// one task per scenario.
module tb_fifo_rd_stream;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        hold_empty = 1'b1;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc, rinc4;
  logic [7:0]  m_data, m_data4;
  logic        m_valid, m_valid4;
  logic [15:0] rd_count;
  logic [3:0]  rd_count4;

  logic [7:0]  mem [0:2047];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q [$];
  int         cnt_m;
  logic       prev_rinc, prev_valid, prev_ready, prev_flush;
  logic [7:0] prev_data;

  always #5 rclk = ~rclk;

  assign rempty = hold_empty || (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr % 2048];

  always @(posedge rclk) begin
    if (rinc) rd_ptr <= rd_ptr + 1;
  end

  fifo_rd_stream #(.DSIZE(8), .CW(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .flush(flush), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .rd_count(rd_count)
  );

  fifo_rd_stream #(.DSIZE(8), .CW(4)) dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
    .rinc(rinc4), .flush(flush), .m_data(m_data4), .m_valid(m_valid4),
    .m_ready(m_ready), .rd_count(rd_count4)
  );

  task automatic push_word(input logic [7:0] w);
    mem[wr_ptr % 2048] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Scoreboard: words enter on rinc, leave on m_valid & m_ready.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge rclk);
      if (!rrst_n) begin
        exp_q.delete();
        cnt_m = 0;
        prev_rinc = 0; prev_valid = 0; prev_ready = 0; prev_flush = 0;
        prev_data = '0;
      end else begin
        total++;
        if (m_valid !== (exp_q.size() != 0)) begin
          bad++; $display("FAIL sb_valid: m_valid=%0b buffered=%0d", m_valid, exp_q.size());
        end
        total++;
        if (rd_count !== 16'(cnt_m) || rd_count4 !== 4'(cnt_m)) begin
          bad++; $display("FAIL sb_count: rd_count=%0d rd_count4=%0d expected %0d", rd_count, rd_count4, cnt_m);
        end
        total++;
        if ((rinc & rempty) !== 1'b0) begin
          bad++; $display("FAIL sb_guard: rinc=%0b while rempty=%0b", rinc, rempty);
        end
        if (prev_rinc) begin
          total++;
          if (m_valid !== 1'b1) begin
            bad++; $display("FAIL sb_latency: m_valid=%0b expected 1", m_valid);
          end
        end
        if (prev_valid && !prev_ready && !prev_flush) begin
          total++;
          if (m_valid !== 1'b1 || m_data !== prev_data) begin
            bad++; $display("FAIL sb_stable: m_valid=%0b m_data=%02h expected 1/%02h", m_valid, m_data, prev_data);
          end
        end
        if (m_valid && m_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL sb_extra: word %02h delivered, expected none", m_data);
          end else begin
            e = exp_q.pop_front();
            if (m_data !== e) begin
              bad++; $display("FAIL sb_order: m_data=%02h expected %02h", m_data, e);
            end
          end
          cnt_m++;
        end
        if (flush) begin
          total++;
          if (rinc !== 1'b0) begin
            bad++; $display("FAIL sb_flush_rinc: rinc=%0b expected 0", rinc);
          end
          exp_q.delete();
        end
        if (rinc) exp_q.push_back(rdata);
        prev_rinc  = rinc;
        prev_valid = m_valid;
        prev_ready = m_ready;
        prev_flush = flush;
        prev_data  = m_data;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge rclk); #1;
    rrst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; hold_empty = 1'b1;
    wr_ptr = rd_ptr;
    repeat (2) @(posedge rclk);
    #1 rrst_n = 1'b1; hold_empty = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge rclk); #1;
    rrst_n = 1'b1; hold_empty = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_word(8'(8'hC0 + i));
    repeat (4) @(posedge rclk);
    #2 rrst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      total++;
      if (rinc !== 1'b0 || m_valid !== 1'b0 || rd_count !== 16'd0 || m_data !== 8'h00 || rd_count4 !== 4'd0) begin
        bad++; $display("FAIL reset: rinc=%0b m_valid=%0b rd_count=%0d m_data=%02h expected 0/0/0/00 (rempty=%0b)",
                        rinc, m_valid, rd_count, m_data, rempty);
      end
    end
    do_reset();
  endtask

  task automatic test_stream();
    int n_rinc, n_pop, first, last;
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push_word(8'(i));
    n_rinc = 0; n_pop = 0; first = -1; last = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge rclk);
      if (rinc) n_rinc++;
      if (m_valid && m_ready) begin
        total++;
        if (m_data !== 8'(n_pop + 1)) begin
          bad++; $display("FAIL stream_data: m_data=%02h expected %02h", m_data, 8'(n_pop + 1));
        end
        if (first < 0) first = c;
        last = c;
        n_pop++;
      end
    end
    total++;
    if (n_rinc != 16 || n_pop != 16) begin
      bad++; $display("FAIL stream_count: rinc pulses=%0d pops=%0d expected 16/16", n_rinc, n_pop);
    end
    total++;
    if (last - first != 15) begin
      bad++; $display("FAIL stream_rate: span=%0d expected 15", last - first);
    end
    total++;
    if (rd_count !== 16'd16 || rinc !== 1'b0) begin
      bad++; $display("FAIL stream_end: rd_count=%0d rinc=%0b expected 16/0", rd_count, rinc);
    end
  endtask

  task automatic test_backpressure();
    int n_rinc, k;
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'(8'hA0 + i));
    n_rinc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      if (rinc) n_rinc++;
    end
    total++;
    if (n_rinc != 2 || rinc !== 1'b0) begin
      bad++; $display("FAIL bp_pulses: rinc pulses=%0d rinc=%0b expected 2/0", n_rinc, rinc);
    end
    total++;
    if (m_valid !== 1'b1 || m_data !== 8'hA0) begin
      bad++; $display("FAIL bp_hold: m_valid=%0b m_data=%02h expected 1/a0", m_valid, m_data);
    end
    @(posedge rclk); #1 m_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      if (m_valid && m_ready) begin
        total++;
        if (m_data !== 8'(8'hA0 + k)) begin
          bad++; $display("FAIL bp_order: m_data=%02h expected %02h", m_data, 8'(8'hA0 + k));
        end
        k++;
      end
    end
    total++;
    if (k != 4) begin
      bad++; $display("FAIL bp_drain: delivered=%0d expected 4", k);
    end
  endtask

  task automatic test_empty_guard();
    int nwr;
    bit drained;
    do_reset();
    nwr = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge rclk); #1;
      hold_empty = ($urandom_range(0, 1) == 1);
      m_ready    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        push_word(8'($urandom_range(0, 255)));
        nwr++;
      end
    end
    @(posedge rclk); #1 hold_empty = 1'b0; m_ready = 1'b1;
    drained = 0;
    for (int c = 0; c < 1200 && !drained; c++) begin
      @(negedge rclk);
      if (rd_ptr == wr_ptr && !m_valid) drained = 1;
    end
    total++;
    if (!drained) begin
      bad++; $display("FAIL guard_drain: left=%0d m_valid=%0b expected 0/0", wr_ptr - rd_ptr, m_valid);
    end
    total++;
    if (rd_count !== 16'(nwr)) begin
      bad++; $display("FAIL guard_count: rd_count=%0d expected %0d", rd_count, nwr);
    end
  endtask

  task automatic test_flush();
    logic [15:0] base;
    do_reset();
    m_ready = 1'b0;
    push_word(8'h55); push_word(8'h66);
    repeat (4) @(negedge rclk);
    total++;
    if (m_valid !== 1'b1 || m_data !== 8'h55 || rinc !== 1'b0) begin
      bad++; $display("FAIL flush_two: m_valid=%0b m_data=%02h rinc=%0b expected 1/55/0", m_valid, m_data, rinc);
    end
    @(posedge rclk); #1;
    push_word(8'h77); flush = 1'b1;
    @(negedge rclk);
    total++;
    if (rinc !== 1'b0) begin
      bad++; $display("FAIL flush_rinc: rinc=%0b expected 0", rinc);
    end
    @(posedge rclk); #1 flush = 1'b0;
    @(negedge rclk);
    total++;
    if (m_valid !== 1'b0 || rinc !== 1'b1) begin
      bad++; $display("FAIL flush_empty: m_valid=%0b rinc=%0b expected 0/1", m_valid, rinc);
    end
    @(negedge rclk);
    total++;
    if (m_valid !== 1'b1 || m_data !== 8'h77) begin
      bad++; $display("FAIL flush_next: m_valid=%0b m_data=%02h expected 1/77", m_valid, m_data);
    end
    @(posedge rclk); #1 m_ready = 1'b1;
    repeat (3) @(posedge rclk);
    #1 base = rd_count;
    for (int i = 0; i < 8; i++) push_word(8'(8'h80 + i));
    repeat (3) @(posedge rclk);
    #1 flush = 1'b1;
    @(posedge rclk); #1 flush = 1'b0;
    repeat (12) @(posedge rclk);
    #1;
    total++;
    if (rd_count - base !== 16'd8 || m_valid !== 1'b0) begin
      bad++; $display("FAIL flush_pop_counts: delivered=%0d m_valid=%0b expected 8/0", rd_count - base, m_valid);
    end
  endtask

  task automatic test_wrap();
    bit hit;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word(8'(8'h30 + i));
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge rclk);
      if (rd_count == 16'd15) hit = 1;
    end
    total++;
    if (!hit || rd_count4 !== 4'd15) begin
      bad++; $display("FAIL wrap_15: reached=%0b rd_count4=%0d expected 1/15", hit, rd_count4);
    end
    @(negedge rclk);
    total++;
    if (rd_count4 !== 4'd0 || rd_count !== 16'd16) begin
      bad++; $display("FAIL wrap_0: rd_count4=%0d rd_count=%0d expected 0/16", rd_count4, rd_count);
    end
    @(negedge rclk);
    total++;
    if (rd_count4 !== 4'd1 || rd_count !== 16'd17) begin
      bad++; $display("FAIL wrap_1: rd_count4=%0d rd_count=%0d expected 1/17", rd_count4, rd_count);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    #12;
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_guard();
    test_flush();
    test_wrap();
    repeat (4) @(posedge rclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
